fft_apb_master: RTL

- APB3 initiator that turns single register-access commands into APB transfers toward the memory_interface register slave.
- Used by the FFT subsystem's host-side sequencer and by integration benches, which issue commands instead of bit-banging psel/penable.
- Accepts one command at a time over a valid/ready handshake and returns one response (read data, slave error, timeout) over a valid/ready handshake.
- Includes a wait-state timeout so a hung slave cannot stall the host.

---
 rtl/fft_apb_pkg.sv | 34 +++
 rtl/fft_apb_master.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fft_apb_pkg.sv
// Shared types and constants for the FFT subsystem APB initiator.
//   apb_state_e : initiator FSM states
//   apb_cmd_t   : host command payload {write, addr, wdata}
//   apb_rsp_t   : host response payload {rdata, error, timeout}
//   CTRL        : memory_interface control register address and bit positions
package fft_apb_pkg;

  localparam int unsigned APB_ADDR_WIDTH = 16;
  localparam int unsigned APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic                      write;
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_DATA_WIDTH-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      error;
    logic                      timeout;
  } apb_rsp_t;

  localparam logic [APB_ADDR_WIDTH-1:0] CTRL = 16'h0000;
  localparam int unsigned CTRL_FFT_START_BIT = 0;
  localparam int unsigned CTRL_FFT_RESET_BIT = 1;

endpackage

// File: rtl/fft_apb_master.sv
// APB3 initiator: converts one valid/ready host command into one APB transfer
// and returns one valid/ready response (read data, slave error, timeout).
// Ports:
//   clk_i, reset_n_i            : clock, async active-low reset
//   cmd_valid_i/cmd_ready_o     : command handshake; cmd_write_i/addr_i/wdata_i payload
//   rsp_valid_o/rsp_ready_i     : response handshake; rsp_rdata_o/error_o/timeout_o payload
//   busy_o                      : FSM not idle
//   psel_o..pwdata_o            : APB request outputs (all registered)
//   prdata_i, pready_i, pslverr_i : APB completion inputs
module fft_apb_master
  import fft_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TMO_CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_error_o,
  output logic                  rsp_timeout_o,
  output logic                  busy_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  localparam logic [TMO_CNT_WIDTH-1:0] TMO_LIMIT = TMO_CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [TMO_CNT_WIDTH-1:0] TMO_MAX   = '1;
  localparam bit                       TMO_EN    = (TIMEOUT_CYCLES != 0);

  apb_state_e               state;
  logic [TMO_CNT_WIDTH-1:0] wait_cnt;
  logic [TMO_CNT_WIDTH-1:0] wait_cnt_inc_c;

  // Saturating increment of the ACCESS wait-state counter.
  assign wait_cnt_inc_c = (wait_cnt == TMO_MAX) ? wait_cnt
                                                : wait_cnt + TMO_CNT_WIDTH'(1);

  // Single-process FSM; every output is a register so async reset clears
  // psel/penable immediately without waiting for a clock edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      cmd_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_error_o   <= 1'b0;
      rsp_timeout_o <= 1'b0;
      busy_o        <= 1'b0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      pwrite_o      <= 1'b0;
      paddr_o       <= '0;
      pwdata_o      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            pwrite_o    <= cmd_write_i;
            paddr_o     <= cmd_addr_i;
            pwdata_o    <= cmd_wdata_i;
            psel_o      <= 1'b1;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            wait_cnt    <= '0;
            state       <= SETUP;
          end
        end

        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
        end

        ACCESS: begin
          // pready is checked first so it wins over a coincident timeout.
          if (pready_i) begin
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_error_o   <= pslverr_i;
            rsp_timeout_o <= 1'b0;
            rsp_rdata_o   <= (pwrite_o || pslverr_i) ? '0 : prdata_i;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt_inc_c;
            if (TMO_EN && (wait_cnt_inc_c == TMO_LIMIT)) begin
              psel_o        <= 1'b0;
              penable_o     <= 1'b0;
              rsp_valid_o   <= 1'b1;
              rsp_error_o   <= 1'b1;
              rsp_timeout_o <= 1'b1;
              rsp_rdata_o   <= '0;
              state         <= RESP;
            end
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_error_o   <= 1'b0;
            rsp_timeout_o <= 1'b0;
            cmd_ready_o   <= 1'b1;
            busy_o        <= 1'b0;
            state         <= IDLE;
          end
        end

        default: begin
          psel_o      <= 1'b0;
          penable_o   <= 1'b0;
          rsp_valid_o <= 1'b0;
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
